// File: rtl/fwd_scoreboard.sv
// Decode-side forwarding scoreboard: tracks in-flight writers, registers EX operand selects, raises load-use stalls.
// Optional FWD_SCOREBOARD_STATS_EN adds saturating stall / forward counters.
module fwd_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SELW       = $clog2(FWD_STAGES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*5-1:0]      id_rs,
  input  logic [4:0]                id_rd,
  input  logic                      id_regs_write,
  input  logic                      id_mem2reg,
  input  logic                      flush,
  output logic                      id_stall,
  output logic [NUM_SRC*SELW-1:0]   ex_fwd_sel
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]               stat_stall_cnt,
  output logic [31:0]               stat_fwd_cnt
`endif
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } tag_t;

  tag_t [FWD_STAGES-1:0]     tag_q;
  tag_t [FWD_STAGES-1:0]     tag_d;
  logic [NUM_SRC*SELW-1:0]   sel_q;
  logic [NUM_SRC*SELW-1:0]   sel_d;
  logic [NUM_SRC*SELW-1:0]   match_sel;
  logic [NUM_SRC-1:0]        ld_hit;
  logic                      accept;

  // Scan oldest to youngest so the youngest visible match overwrites.
  always_comb begin
    match_sel = '0;
    ld_hit    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = FWD_STAGES - 2; j >= 0; j--) begin
        if (tag_q[j].valid && tag_q[j].rw &&
            tag_q[j].rd != 5'd0 &&
            tag_q[j].rd == id_rs[5*i +: 5]) begin
          match_sel[SELW*i +: SELW] = SELW'(j + 1);
          ld_hit[i] = tag_q[j].ld && (j < LOAD_LAT);
        end
      end
    end
  end

  assign id_stall = id_valid && !flush && !rst && (|ld_hit);
  assign accept   = id_valid && !id_stall && !flush;

  always_comb begin
    tag_d = '0;
    if (accept) begin
      tag_d[0].valid = 1'b1;
      tag_d[0].rd    = id_rd;
      tag_d[0].rw    = id_regs_write;
      tag_d[0].ld    = id_mem2reg;
    end
    for (int k = 1; k < FWD_STAGES; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    sel_d = accept ? match_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      sel_q <= '0;
    end else begin
      tag_q <= tag_d;
      sel_q <= sel_d;
    end
  end

  assign ex_fwd_sel = sel_q;

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] fwd_cnt_q;
  logic [31:0] fwd_cnt_d;
  logic [31:0] nz_cnt;
  logic [32:0] fwd_sum;

  always_comb begin
    nz_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      nz_cnt = nz_cnt + 32'(|sel_d[SELW*i +: SELW]);
    end
    fwd_sum     = {1'b0, fwd_cnt_q} + {1'b0, nz_cnt};
    fwd_cnt_d   = fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
    stall_cnt_d = stall_cnt_q;
    if (id_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
  assign stat_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the EX-stage forwarding unit. Tracks in-flight register writers in an internal tag pipeline of FWD_STAGES entries; stage 0 is EX and stage FWD_STAGES-1 is the last stage before regfile write.
- At decode it compares each source register against the in-flight tags. It registers a forwarding select for the EX stage and raises a load-use stall when the producer's data will not be ready in time.
- Sits between the decode and EX stages; the EX-stage operand muxes are driven by ex_fwd_sel.

Parameters:
- NUM_SRC, 2, number of source operands per instruction (rs1, rs2, ...).
- FWD_STAGES, 3, number of tracked stages (EX, MEM, WB, ...); must be >= 2.
- LOAD_LAT, 1, extra stages after EX before load data can be forwarded; 1..FWD_STAGES-2.
- SELW, $clog2(FWD_STAGES), width of one select field (derived, do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs  in  NUM_SRC*5  packed source register numbers; src i is bits [5i+4:5i].
- id_rd  in  5  destination register.
- id_regs_write  in  1  instruction writes rd.
- id_mem2reg  in  1  instruction is a load.
- flush  in  1  kill the instruction in decode and the one entering EX.
- id_stall  out  1  hold IF/ID and insert a bubble into EX (combinational).
- ex_fwd_sel  out  NUM_SRC*SELW  registered per-source select: 0 = ID/EX (regfile) value, k = result held in stage k (1..FWD_STAGES-1).

Behaviour:
- Tag entry per stage: valid, rd, regs_write, is_load. On reset all entries are cleared and ex_fwd_sel = 0.
- Advance every cycle; there is no global hold:
  - stage[k] <= stage[k-1] for k >= 1.
  - stage[0] <= decode entry if id_valid && !id_stall && !flush, else a bubble (valid = 0).
- Match for src i at stage j (j in 0..FWD_STAGES-2) requires all of: stage[j].valid, regs_write, rd != 0, rd == id_rs[i].
  - Youngest match (lowest j) wins.
  - The producer will sit in stage j+1 when the consumer reaches EX.
- Stall: if id_valid and the youngest match for any src is a load with j+1 < 1+LOAD_LAT, then id_stall = 1.
  - With LOAD_LAT = 1 this means a load currently in EX (j = 0): the classic 1-cycle load-use bubble.
  - The stall repeats each cycle until the condition clears, so a deeper LOAD_LAT gives a multi-cycle stall.
- ex_fwd_sel[i] <= (match ? j+1 : 0) when a decode entry is accepted; <= 0 when a bubble is inserted (stall or flush).
  - Latency: the select is valid in the same cycle the consumer's tag is in stage 0.
- src register x0 never matches.
- Producers at stage FWD_STAGES-1 are not visible to decode; the regfile is write-through at that point.
- id_stall is gated by id_valid and forced 0 during rst. flush wins over stall: the bubble is inserted and no stall is asserted that cycle.
- Reset mid-operation clears every in-flight tag; no stale forwarding after rst deasserts.

Optional Feature:
- Macro FWD_SCOREBOARD_STATS_EN.
- Defined: adds outputs stat_stall_cnt (out, 32) and stat_fwd_cnt (out, 32).
  - stat_stall_cnt increments each cycle id_stall = 1.
  - stat_fwd_cnt increments by the number of nonzero select fields written into ex_fwd_sel.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: these ports and counters do not exist; functional behaviour is identical.

Test Plan:
- FWD_STAGES=3: add x5 then add x6,x5,x5 back-to-back -> no stall; ex_fwd_sel = {2'd1, 2'd1} while the consumer is in EX.
- add x5; nop; sub x7,x5,x0 -> ex_fwd_sel src0 = 2, src1 = 0.
- lw x8; add x9,x8,x1 -> id_stall = 1 for exactly 1 cycle; bubble in EX; consumer then gets src0 sel = 2.
- LOAD_LAT=2, FWD_STAGES=4: lw x8; add x9,x8,x8 -> id_stall for 2 cycles, then sel = {3, 3}.
- Writer to x0 followed by a reader of x0 -> sel 0, no stall. add x5 followed by add x5 then a reader of x5 -> youngest wins, sel = 1.
- rst asserted with a load in EX and a dependent in decode -> next cycle id_stall = 0, ex_fwd_sel = 0, all tags invalid. With FWD_SCOREBOARD_STATS_EN, the counters read 0.
